// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one registered req/ack bus access per memory op, load alignment/extension, precise traps.
// Non-memory ops: 1 cycle. Memory ops: 2 cycles when the ack arrives in the first WAIT cycle. o_stall holds upstream while an access is open.
module lsu_mem_stage #(
  parameter int XLEN    = 32,
  parameter int XADDR   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic [XLEN-1:0]   i_rs2,
  input  logic [XADDR-1:0]  i_rd_addr,
  input  logic              i_rd_write,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_flush,
  input  logic              i_stall,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_wstrb,
  input  logic              i_mem_ack,
  input  logic              i_mem_err,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_wb_valid,
  output logic [XLEN-1:0]   o_wb_pc,
  output logic [XADDR-1:0]  o_wb_rd_addr,
  output logic              o_wb_rd_write,
  output logic [XLEN-1:0]   o_wb_rd_data,
  output logic              o_trap,
  output logic [3:0]        o_trap_cause,
  output logic [XLEN-1:0]   o_trap_addr
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [6:0] L_OP = 7'b0000011;
  localparam logic [6:0] S_OP = 7'b0100011;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XADDR-1:0] rd_addr;
    logic             rd_write;
    logic [XLEN-1:0]  rd_data;
    logic             trap;
    logic [3:0]       cause;
    logic [XLEN-1:0]  trap_addr;
  } wb_t;

  logic [1:0]      state;
  logic [TW-1:0]   tcnt;
  logic            kill;
  logic [XLEN-1:0] op_pc;
  logic [XADDR-1:0] op_rd;
  logic            op_rdw;
  logic [2:0]      op_f3;
  logic            op_we;
  logic [XLEN-1:0] op_addr;
  logic            wb_vld;
  wb_t             wb;
  wb_t             hold;

  // Issue-side decode
  logic            is_load, is_store, is_mem, illegal, misal, mem_ok, accept;
  logic [OFFW-1:0] off;
  logic [1:0]      sz;

  always_comb begin
    is_load  = (i_opcode == L_OP);
    is_store = (i_opcode == S_OP);
    is_mem   = is_load | is_store;
    sz       = i_funct3[1:0];
    off      = i_alu_result[OFFW-1:0];
    illegal  = 1'b0;
    if (is_load)
      illegal = (i_funct3 == 3'b111) |
                ((XLEN == 32) & ((i_funct3 == 3'b011) | (i_funct3 == 3'b110)));
    else if (is_store)
      illegal = (XLEN == 32) ? (i_funct3 >= 3'b011) : (i_funct3 >= 3'b100);
    misal  = ((sz == 2'd1) & i_alu_result[0]) |
             ((sz == 2'd2) & (|i_alu_result[1:0])) |
             ((sz == 2'd3) & (|i_alu_result[2:0]));
    mem_ok = is_mem & ~illegal & ~misal;
    accept = (state == S_IDLE) & i_valid & ~i_stall & ~i_flush;
  end

  logic [XLEN-1:0] st_wdata, al_addr;
  logic [NB-1:0]   st_strb;
  logic [7:0]      strb_base;

  always_comb begin
    case (sz)
      2'd0:    begin st_wdata = {NB{i_rs2[7:0]}};       strb_base = 8'h01; end
      2'd1:    begin st_wdata = {(NB/2){i_rs2[15:0]}};  strb_base = 8'h03; end
      2'd2:    begin st_wdata = {(NB/4){i_rs2[31:0]}};  strb_base = 8'h0F; end
      default: begin st_wdata = i_rs2;                  strb_base = 8'hFF; end
    endcase
    st_strb = NB'(strb_base) << off;
    al_addr = i_alu_result;
    al_addr[OFFW-1:0] = '0;
  end

  // Completion side: lane extraction and extension of the returned word
  logic [XLEN-1:0] sh, ld_data;
  logic            timeout_hit, done, fault;
  wb_t             res, imm;

  always_comb begin
    sh = i_mem_rdata >> {op_addr[OFFW-1:0], 3'b000};
    case (op_f3)
      3'b000:  ld_data = XLEN'($signed(sh[7:0]));
      3'b001:  ld_data = XLEN'($signed(sh[15:0]));
      3'b010:  ld_data = XLEN'($signed(sh[31:0]));
      3'b100:  ld_data = XLEN'(sh[7:0]);
      3'b101:  ld_data = XLEN'(sh[15:0]);
      3'b110:  ld_data = XLEN'(sh[31:0]);
      default: ld_data = sh;
    endcase
    timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
    done        = i_mem_ack | timeout_hit;
    // An ack in the timeout cycle still completes the access normally
    fault       = i_mem_ack ? i_mem_err : 1'b1;

    res.pc        = op_pc;
    res.rd_addr   = op_rd;
    res.rd_write  = op_rdw & ~op_we & ~fault;
    res.rd_data   = (fault | op_we) ? '0 : ld_data;
    res.trap      = fault;
    res.cause     = op_we ? 4'd7 : 4'd5;
    res.trap_addr = op_addr;

    imm.pc        = i_pc;
    imm.rd_addr   = i_rd_addr;
    imm.rd_write  = i_rd_write & ~is_mem;
    imm.rd_data   = is_mem ? '0 : i_alu_result;
    imm.trap      = is_mem;
    imm.cause     = illegal ? 4'd2 : (is_store ? 4'd6 : 4'd4);
    imm.trap_addr = is_mem ? i_alu_result : '0;
  end

  assign o_stall = ((state == S_IDLE) & i_valid & ~i_flush & mem_ok) |
                   ((state == S_WAIT) & (~done | i_stall)) |
                   (state == S_HOLD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      kill        <= 1'b0;
      op_pc       <= '0;
      op_rd       <= '0;
      op_rdw      <= 1'b0;
      op_f3       <= '0;
      op_we       <= 1'b0;
      op_addr     <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
      wb_vld      <= 1'b0;
      wb          <= '0;
      hold        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (mem_ok) begin
              o_mem_req   <= 1'b1;
              o_mem_we    <= is_store;
              o_mem_addr  <= al_addr;
              o_mem_wdata <= is_store ? st_wdata : '0;
              o_mem_wstrb <= is_store ? st_strb : '0;
              op_pc       <= i_pc;
              op_rd       <= i_rd_addr;
              op_rdw      <= i_rd_write;
              op_f3       <= i_funct3;
              op_we       <= is_store;
              op_addr     <= i_alu_result;
              tcnt        <= '0;
              wb_vld      <= 1'b0;
              state       <= S_WAIT;
            end else begin
              wb_vld <= 1'b1;
              wb     <= imm;
            end
          end else if (i_flush || !i_stall) begin
            wb_vld <= 1'b0;
          end
        end
        S_WAIT: begin
          if (done) begin
            o_mem_req <= 1'b0;
            tcnt      <= '0;
            kill      <= 1'b0;
            if (kill || i_flush) begin
              state <= S_IDLE;
            end else if (!i_stall) begin
              wb     <= res;
              wb_vld <= 1'b1;
              state  <= S_IDLE;
            end else begin
              hold  <= res;
              state <= S_HOLD;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
            if (i_flush) kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (i_flush) begin
            state <= S_IDLE;
          end else if (!i_stall) begin
            wb     <= hold;
            wb_vld <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_wb_valid    = wb_vld;
  assign o_wb_pc       = wb.pc;
  assign o_wb_rd_addr  = wb.rd_addr;
  assign o_wb_rd_write = wb.rd_write;
  assign o_wb_rd_data  = wb.rd_data;
  assign o_trap        = wb_vld & wb.trap;
  assign o_trap_cause  = wb.cause;
  assign o_trap_addr   = wb.trap_addr;

endmodule
